jelly_data_split_id: RTL and testbench

JELLY_DATA_SPLIT_ID -- requirements
Module: jelly_data_split_id

---
 rtl/jelly_data_split_id.sv | 216 +++++++++++++++++++++
 tb/tb_jelly_data_split_id.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_data_split_id.sv
// ---------------------------------------------------------------------------
// jelly_data_split_id
//   Routes one input stream to NUM output streams, using the per-word id as
//   the target port. Words whose id has no matching port are accepted and
//   discarded without stalling the input.
//
//   Parameters
//     NUM        number of output ports
//     ID_WIDTH   width of the routing id
//     DATA_WIDTH payload width
//     S_REGS     1 = two-entry skid stage on the input (s_ready from a flop)
//     M_REGS     1 = two-entry skid stage on every output port
//
//   Ports
//     clk, reset           rising-edge clock, synchronous active-high reset
//     cke                  clock enable, all state holds while 0
//     s_id/s_data/s_valid/s_ready   input stream
//     m_data/m_valid/m_ready        output streams, port i at
//                                   m_data[i*DATA_WIDTH +: DATA_WIDTH]
//     err_drop             one-cycle pulse per discarded word
//     err_count            saturating count of discarded words
//
//   Build option: define JELLY_DATA_SPLIT_ID_ERR_COUNT_EN to enable
//   err_drop/err_count; otherwise both are tied to 0.
//
//   Handshake: a word moves across an interface at a rising clk edge where
//   cke=1 and both valid and ready are 1. Once valid is raised it stays
//   raised with stable data until that transfer happens.
// ---------------------------------------------------------------------------

// Two-entry skid buffer. s_ready_o is a flop output, and the stage takes a
// new word in the same cycle its head word is consumed, so a stream with
// ready held high passes one word per cycle.
module jelly_data_split_id_skid #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cke,
   input  logic [WIDTH-1:0] s_data_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i
);
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic             push, pop;

   assign s_ready_o = ~skid_v_q;
   assign m_data_o  = main_q;
   assign m_valid_o = main_v_q;
   assign push      = s_valid_i & ~skid_v_q;
   assign pop       = main_v_q & m_ready_i;

   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (!main_v_q || pop) begin
         if (skid_v_q) begin
            // skid full means no push this cycle; promote the skid word
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
         end else begin
            main_d   = s_data_i;
            main_v_d = push;
         end
      end else if (push) begin
         // head is blocked: park the incoming word
         skid_d   = s_data_i;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else if (cke) begin
         main_q   <= main_d;
         main_v_q <= main_v_d;
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
      end
   end
endmodule

module jelly_data_split_id #(
   parameter int NUM        = 16,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int S_REGS     = 1,
   parameter int M_REGS     = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cke,
   input  logic [ID_WIDTH-1:0]       s_id,
   input  logic [DATA_WIDTH-1:0]     s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [NUM*DATA_WIDTH-1:0] m_data,
   output logic [NUM-1:0]            m_valid,
   input  logic [NUM-1:0]            m_ready,
   output logic                      err_drop,
   output logic [15:0]               err_count
);
   localparam int W = ID_WIDTH + DATA_WIDTH;

   // head word: the one currently presented to the router
   logic [ID_WIDTH-1:0]   head_id;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_valid;
   logic                  head_ready;
   logic                  in_range;
   logic [NUM-1:0]        port_valid;
   logic [NUM-1:0]        port_ready;

   generate
      if (S_REGS != 0) begin : g_sreg
         logic [W-1:0] head_word;
         logic         in_ready;
         jelly_data_split_id_skid #(.WIDTH(W)) u_in (
            .clk       (clk),
            .reset     (reset),
            .cke       (cke),
            .s_data_i  ({s_id, s_data}),
            .s_valid_i (s_valid),
            .s_ready_o (in_ready),
            .m_data_o  (head_word),
            .m_valid_o (head_valid),
            .m_ready_i (head_ready)
         );
         assign {head_id, head_data} = head_word;
         assign s_ready = in_ready & ~reset;
      end else begin : g_scomb
         assign head_id    = s_id;
         assign head_data  = s_data;
         assign head_valid = s_valid;
         assign s_ready    = head_ready & ~reset;
      end
   endgenerate

   // Route the head word. An id with no port is always "ready" so the word
   // is consumed in one cycle and dropped.
   always_comb begin
      in_range   = 1'b0;
      head_ready = 1'b1;
      port_valid = '0;
      for (int i = 0; i < NUM; i++) begin
         if (head_id == ID_WIDTH'(i)) begin
            in_range      = 1'b1;
            head_ready    = port_ready[i];
            port_valid[i] = head_valid;
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM; i++) begin : g_port
         if (M_REGS != 0) begin : g_mreg
            jelly_data_split_id_skid #(.WIDTH(DATA_WIDTH)) u_out (
               .clk       (clk),
               .reset     (reset),
               .cke       (cke),
               .s_data_i  (head_data),
               .s_valid_i (port_valid[i]),
               .s_ready_o (port_ready[i]),
               .m_data_o  (m_data[i*DATA_WIDTH +: DATA_WIDTH]),
               .m_valid_o (m_valid[i]),
               .m_ready_i (m_ready[i])
            );
         end else begin : g_mcomb
            assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = head_data;
            assign m_valid[i]    = port_valid[i];
            assign port_ready[i] = m_ready[i];
         end
      end
   endgenerate

`ifdef JELLY_DATA_SPLIT_ID_ERR_COUNT_EN
   logic        err_drop_q, err_drop_d;
   logic [15:0] err_count_q, err_count_d;

   // an out-of-range head is always consumed, so valid alone marks a drop
   always_comb begin
      err_drop_d  = head_valid & ~in_range;
      err_count_d = err_count_q;
      if (err_drop_d && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_drop_q  <= 1'b0;
         err_count_q <= 16'd0;
      end else if (cke) begin
         err_drop_q  <= err_drop_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_drop  = err_drop_q;
   assign err_count = err_count_q;
`else
   logic unused_in_range;
   assign unused_in_range = in_range;
   assign err_drop  = 1'b0;
   assign err_count = 16'd0;
`endif
endmodule

// File: tb/tb_jelly_data_split_id.sv
// Bench for jelly_data_split_id: a 16-port default instance checked by a
// per-port-ordered scoreboard, and a 10-port instance for out-of-range ids.
module tb_jelly_data_split_id;
   localparam int NUM = 16;
   localparam int DW  = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic cke;
   always #5 clk = ~clk;

   // ---------------- 16-port instance ----------------
   logic [3:0]        s_id;
   logic [DW-1:0]     s_data;
   logic              s_valid, s_ready;
   logic [NUM*DW-1:0] m_data;
   logic [NUM-1:0]    m_valid, m_ready;
   logic              err_drop;
   logic [15:0]       err_count;

   jelly_data_split_id dut (
      .clk(clk), .reset(reset), .cke(cke),
      .s_id(s_id), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .err_drop(err_drop), .err_count(err_count)
   );

   // ---------------- 10-port instance ----------------
   logic [3:0]     t_id;
   logic [DW-1:0]  t_data;
   logic           t_valid, t_ready;
   logic [10*DW-1:0] t_m_data;
   logic [9:0]     t_m_valid, t_m_ready;
   logic           t_err_drop;
   logic [15:0]    t_err_count;

   jelly_data_split_id #(.NUM(10), .ID_WIDTH(4), .DATA_WIDTH(32)) dut10 (
      .clk(clk), .reset(reset), .cke(cke),
      .s_id(t_id), .s_data(t_data), .s_valid(t_valid), .s_ready(t_ready),
      .m_data(t_m_data), .m_valid(t_m_valid), .m_ready(t_m_ready),
      .err_drop(t_err_drop), .err_count(t_err_count)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [35:0] exp_q[$];   // {port, data}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: a transfer happens at the next posedge when valid&ready here
   int idx;
   always @(negedge clk) begin
      if (cke && !reset) begin
         for (int p = 0; p < NUM; p++) begin
            if (m_valid[p] && m_ready[p]) begin
               idx = -1;
               for (int k = 0; k < exp_q.size(); k++) begin
                  if (exp_q[k][35:32] == p[3:0]) begin
                     idx = k;
                     break;
                  end
               end
               if (idx < 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: port %0d got %0h expected none", p, m_data[p*DW +: DW]);
               end else begin
                  check($sformatf("port%0d_data", p), 64'(m_data[p*DW +: DW]), 64'(exp_q[idx][31:0]));
                  exp_q.delete(idx);
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [3:0] id, input logic [31:0] data, output int waited);
      bit acc;
      acc    = 1'b0;
      waited = 0;
      s_id    = id;
      s_data  = data;
      s_valid = 1'b1;
      while (!acc && waited < 200) begin
         @(negedge clk);
         acc = s_ready && cke && !reset;
         if (acc) exp_q.push_back({id, data});
         @(posedge clk); #1;
         if (!acc) waited++;
      end
      s_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: id %0d not accepted, required accept within 200 cycles", id);
      end
   endtask

   // ---------------- stimulus ----------------
   int w, w6, stalls;
   logic [NUM-1:0]    snap_v;
   logic [NUM*DW-1:0] snap_d;
   logic [15:0]       exp_cnt;
   logic              exp_pulse;

   initial begin
      reset = 1'b1; cke = 1'b1;
      s_valid = 1'b0; s_id = '0; s_data = '0; m_ready = '1;
      t_valid = 1'b0; t_id = '0; t_data = '0; t_m_ready = '1;
`ifdef JELLY_DATA_SPLIT_ID_ERR_COUNT_EN
      exp_cnt = 16'd3; exp_pulse = 1'b1;
`else
      exp_cnt = 16'd0; exp_pulse = 1'b0;
`endif

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      check("rst_err_drop", 64'(err_drop), 64'd0);
      reset = 1'b0;
      #1;
      check("s_ready_after_rst", 64'(s_ready), 64'd1);

      // single word, latency 2
      send(4'd3, 32'hA5A5_0003, w);
      check("lat_c1_m_valid", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_c2_m_valid", 64'(m_valid), 64'h0008);
      check("lat_c2_m_data3", 64'(m_data[3*DW +: DW]), 64'hA5A5_0003);
      repeat (3) @(posedge clk);
      #1;

      // back-to-back ids 0..15
      stalls = 0;
      for (int i = 0; i < 16; i++) begin
         send(i[3:0], 32'h3100_0000 + i, w);
         stalls += w;
      end
      check("b2b_no_stall", 64'(stalls), 64'd0);
      repeat (4) @(posedge clk);
      #1;

      // head-of-line blocking on port 5
      m_ready[5] = 1'b0;
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         send(4'd5, 32'h5500_0000 + i, w);
         stalls += w;
      end
      check("hol_fill_no_stall", 64'(stalls), 64'd0);
      fork
         send(4'd6, 32'h6600_0006, w6);
         begin
            repeat (5) @(negedge clk);
            check("hol_s_ready_low", 64'(s_ready), 64'd0);
            check("hol_m_valid6_low", 64'(m_valid[6]), 64'd0);
            check("hol_m_valid5_held", 64'(m_valid[5]), 64'd1);
            check("hol_m_data5_head", 64'(m_data[5*DW +: DW]), 64'h5500_0000);
            @(posedge clk); #1;
            m_ready[5] = 1'b1;
         end
      join
      check("hol_id6_stalled", 64'(w6 > 0), 64'd1);
      repeat (8) @(posedge clk);
      #1;
      check("hol_drained", 64'(exp_q.size()), 64'd0);

      // reset with two words parked on port 7
      m_ready[7] = 1'b0;
      send(4'd7, 32'h7700_0001, w);
      send(4'd7, 32'h7700_0002, w);
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_m_valid7", 64'(m_valid[7]), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_s_ready", 64'(s_ready), 64'd0);
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
         if (exp_q[k][35:32] == 4'd7) exp_q.delete(k);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      check("post_rst_m_valid", 64'(m_valid), 64'd0);
      m_ready[7] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("post_rst_quiet", 64'(m_valid), 64'd0);
      end

      // cke low for 5 cycles mid-stream
      fork
         for (int i = 0; i < 10; i++) send(i[3:0], 32'h3500_0000 + i, w);
         begin
            repeat (4) @(posedge clk);
            #1;
            cke = 1'b0;
            snap_v = m_valid;
            snap_d = m_data;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               check("cke_frozen_valid", 64'(m_valid), 64'(snap_v));
               check("cke_frozen_data", 64'(m_data === snap_d), 64'd1);
            end
            @(posedge clk); #1;
            cke = 1'b1;
         end
      join

      // out-of-range ids on the 10-port instance
      t_valid = 1'b1;
      t_id    = 4'd12;
      for (int i = 0; i < 3; i++) begin
         t_data = 32'hC000_0000 + i;
         @(negedge clk);
         check("drop_s_ready", 64'(t_ready), 64'd1);
         check("drop_m_valid", 64'(t_m_valid), 64'd0);
         @(posedge clk); #1;
      end
      t_id   = 4'd9;
      t_data = 32'h9999_0009;
      @(negedge clk);
      check("t_in_ready", 64'(t_ready), 64'd1);
      @(posedge clk); #1;
      t_valid = 1'b0;
      check("drop_m_valid_c1", 64'(t_m_valid), 64'd0);
      check("drop_err_pulse", 64'(t_err_drop), 64'(exp_pulse));
      @(posedge clk); #1;
      check("t_m_valid9", 64'(t_m_valid), 64'h200);
      check("t_m_data9", 64'(t_m_data[9*DW +: DW]), 64'h9999_0009);
      check("drop_err_count", 64'(t_err_count), 64'(exp_cnt));
      check("drop_err_pulse_end", 64'(t_err_drop), 64'd0);

      // drain and final checks
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("dut16_err_count", 64'(err_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
